// File: rtl/program_sequencer.sv
// Two-phase (FETCH/EXEC) program sequencer with a circular return-address stack.
// FETCH latches the instruction and increments pc. EXEC decodes branches,
// calls and returns, and can flush the following instruction on a skip request.
module program_sequencer #(
  parameter int STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [10:0]                    rom_addr,
  input  logic [13:0]                    rom_data,
  input  logic                           stall,
  input  logic                           skip,
  output logic [13:0]                    ir,
  output logic                           ir_valid,
  output logic [10:0]                    pc,
  output logic [$clog2(STACK_DEPTH)-1:0] sp,
  output logic                           stack_err
);

  localparam int SP_W    = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = SP_W + 1;

  if (STACK_DEPTH < 2 || STACK_DEPTH > 16 || (1 << SP_W) != STACK_DEPTH) begin : g_bad_depth
    $error("STACK_DEPTH must be a power of two from 2 to 16");
  end

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [10:0]        r_pc;
  logic [13:0]        r_ir;
  logic [SP_W-1:0]    r_sp;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_flush;
  logic               r_err;
  logic [10:0]        r_stack [STACK_DEPTH];

  logic               w_is_goto;
  logic               w_is_call;
  logic               w_is_ret;
  logic               w_decode;
  logic               w_push;
  logic [SP_W-1:0]    w_sp_inc;
  logic [SP_W-1:0]    w_sp_dec;
  logic               w_full;
  logic               w_empty;

  assign rom_addr  = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign sp        = r_sp;
  assign stack_err = r_err;
  assign ir_valid  = (r_state == EXEC) && !r_flush;

  assign w_is_goto = (r_ir[13:11] == 3'b101);
  assign w_is_call = (r_ir[13:11] == 3'b100);
  assign w_is_ret  = (r_ir == 14'h0008) || (r_ir[13:10] == 4'b1101);
  assign w_decode  = (r_state == EXEC) && !r_flush;
  assign w_push    = w_decode && w_is_call;
  assign w_sp_inc  = r_sp + SP_W'(1);
  assign w_sp_dec  = r_sp - SP_W'(1);
  assign w_full    = (r_depth == DEPTH_W'(STACK_DEPTH));
  assign w_empty   = (r_depth == '0);

  // Next-state: strict alternation between FETCH and EXEC
  always_comb begin
    w_state_nxt = FETCH;
    if (r_state == FETCH) w_state_nxt = EXEC;
  end

  // State register; stall freezes the phase
  always_ff @(posedge clk) begin
    if (reset)       r_state <= FETCH;
    else if (!stall) r_state <= w_state_nxt;
  end

  // Fetch latch, pc update, decode and stack bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_sp    <= '0;
      r_depth <= '0;
      r_flush <= 1'b0;
      r_err   <= 1'b0;
    end else if (!stall) begin
      if (r_state == FETCH) begin
        r_ir <= rom_data;
        r_pc <= r_pc + 11'd1;
      end else if (r_flush) begin
        r_flush <= 1'b0;
      end else if (w_is_goto) begin
        r_pc <= r_ir[10:0];
      end else if (w_is_call) begin
        r_sp <= w_sp_inc;
        r_pc <= r_ir[10:0];
        if (w_full) r_err   <= 1'b1;
        else        r_depth <= r_depth + DEPTH_W'(1);
      end else if (w_is_ret) begin
        r_sp <= w_sp_dec;
        r_pc <= r_stack[w_sp_dec];
        if (w_empty) r_err   <= 1'b1;
        else         r_depth <= r_depth - DEPTH_W'(1);
      end else if (skip) begin
        r_flush <= 1'b1;
      end
    end
  end

  // Return-address storage; pc already holds the return address during EXEC
  always_ff @(posedge clk) begin
    if (!reset && !stall && w_push) r_stack[r_sp] <= r_pc;
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with a behavioural ROM.
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic        stall;
  logic        skip;
  logic [13:0] ir;
  logic        ir_valid;
  logic [10:0] pc;
  logic [2:0]  sp;
  logic        stack_err;

  logic [13:0] rom [2048];
  int          n_cmp = 0;
  int          n_err = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  program_sequencer #(.STACK_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .stall     (stall),
    .skip      (skip),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .sp        (sp),
    .stack_err (stack_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    skip  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 14'h0123;
    do_reset();
    n_cmp++; if (pc !== 11'h000)       begin n_err++; $display("FAIL reset_pc: got %h want 000", pc); end
    n_cmp++; if (rom_addr !== 11'h000) begin n_err++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
    n_cmp++; if (ir !== 14'h0000)      begin n_err++; $display("FAIL reset_ir: got %h want 0000", ir); end
    n_cmp++; if (ir_valid !== 1'b0)    begin n_err++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
    n_cmp++; if (sp !== 3'd0)          begin n_err++; $display("FAIL reset_sp: got %0d want 0", sp); end
    n_cmp++; if (stack_err !== 1'b0)   begin n_err++; $display("FAIL reset_err: got %b want 0", stack_err); end
    tick();
    n_cmp++; if (ir !== 14'h0123)      begin n_err++; $display("FAIL reset_first_fetch: got %h want 0123", ir); end
  endtask

  task automatic load_straight();
    clear_rom();
    rom[0] = 14'h01A5; rom[1] = 14'h0103; rom[2] = 14'h3007;
    rom[3] = 14'h07A5; rom[4] = 14'h0725; rom[5] = 14'h2805;
  endtask

  task automatic test_straight_line();
    logic [13:0] exp_ir [6];
    logic [10:0] exp_pc;
    exp_ir = '{14'h01A5, 14'h0103, 14'h3007, 14'h07A5, 14'h0725, 14'h2805};
    load_straight();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_pc = (k < 5) ? 11'(k + 1) : 11'h006;
      n_cmp++; if (ir_valid !== 1'b1)          begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", k, ir_valid); end
      n_cmp++; if (ir !== exp_ir[(k < 5) ? k : 5]) begin n_err++; $display("FAIL seq_ir[%0d]: got %h want %h", k, ir, exp_ir[(k < 5) ? k : 5]); end
      n_cmp++; if (pc !== exp_pc)              begin n_err++; $display("FAIL seq_pc_exec[%0d]: got %h want %h", k, pc, exp_pc); end
      tick();
      exp_pc = (k < 5) ? 11'(k + 1) : 11'h005;
      n_cmp++; if (ir_valid !== 1'b0)          begin n_err++; $display("FAIL seq_fetch_valid[%0d]: got %b want 0", k, ir_valid); end
      n_cmp++; if (pc !== exp_pc)              begin n_err++; $display("FAIL seq_pc_fetch[%0d]: got %h want %h", k, pc, exp_pc); end
    end
  endtask

  task automatic test_call_return();
    clear_rom();
    rom[0] = 14'h2010; rom[1] = 14'h2020; rom[11'h010] = 14'h0008; rom[11'h020] = 14'h3455;
    do_reset();
    tick(); tick();
    n_cmp++; if (pc !== 11'h010)              begin n_err++; $display("FAIL call_pc: got %h want 010", pc); end
    n_cmp++; if (sp !== 3'd1)                 begin n_err++; $display("FAIL call_sp: got %0d want 1", sp); end
    n_cmp++; if (dut.r_stack[0] !== 11'h001)  begin n_err++; $display("FAIL call_stack0: got %h want 001", dut.r_stack[0]); end
    tick();
    n_cmp++; if (ir !== 14'h0008)             begin n_err++; $display("FAIL ret_fetch: got %h want 0008", ir); end
    tick();
    n_cmp++; if (pc !== 11'h001)              begin n_err++; $display("FAIL ret_pc: got %h want 001", pc); end
    n_cmp++; if (sp !== 3'd0)                 begin n_err++; $display("FAIL ret_sp: got %0d want 0", sp); end
    n_cmp++; if (stack_err !== 1'b0)          begin n_err++; $display("FAIL ret_err: got %b want 0", stack_err); end
    tick(); tick();
    n_cmp++; if (pc !== 11'h020)              begin n_err++; $display("FAIL call2_pc: got %h want 020", pc); end
    tick(); tick();
    n_cmp++; if (pc !== 11'h002)              begin n_err++; $display("FAIL retlw_pc: got %h want 002", pc); end
    n_cmp++; if (sp !== 3'd0)                 begin n_err++; $display("FAIL retlw_sp: got %0d want 0", sp); end
  endtask

  task automatic test_skip();
    clear_rom();
    rom[0] = 14'h0100; rom[1] = 14'h0101; rom[2] = 14'h0102;
    rom[3] = 14'h2020; rom[4] = 14'h2806; rom[6] = 14'h0106;
    do_reset();
    tick(); tick(); tick(); tick(); tick();
    n_cmp++; if (ir !== 14'h0102) begin n_err++; $display("FAIL skip_setup_ir: got %h want 0102", ir); end
    skip = 1'b1;
    tick();
    skip = 1'b0;
    tick();
    n_cmp++; if (ir !== 14'h2020)   begin n_err++; $display("FAIL skip_flushed_ir: got %h want 2020", ir); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL skip_flushed_valid: got %b want 0", ir_valid); end
    skip = 1'b1;
    tick();
    skip = 1'b0;
    n_cmp++; if (pc !== 11'h004)    begin n_err++; $display("FAIL skip_no_redirect: got %h want 004", pc); end
    n_cmp++; if (sp !== 3'd0)       begin n_err++; $display("FAIL skip_no_push: got %0d want 0", sp); end
    tick();
    n_cmp++; if (ir !== 14'h2806)   begin n_err++; $display("FAIL skip_next_ir: got %h want 2806", ir); end
    n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL skip_next_valid: got %b want 1", ir_valid); end
    skip = 1'b1;
    tick();
    skip = 1'b0;
    n_cmp++; if (pc !== 11'h006)    begin n_err++; $display("FAIL skip_goto_pc: got %h want 006", pc); end
    tick();
    n_cmp++; if (ir !== 14'h0106)   begin n_err++; $display("FAIL skip_goto_ir: got %h want 0106", ir); end
    n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL skip_goto_valid: got %b want 1", ir_valid); end
  endtask

  task automatic test_stack_limits();
    clear_rom();
    for (int i = 0; i < 9; i++) rom[i] = 14'h2000 | 14'(i + 1);
    do_reset();
    for (int i = 0; i < 8; i++) begin tick(); tick(); end
    n_cmp++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL full_err: got %b want 0", stack_err); end
    n_cmp++; if (sp !== 3'd0)        begin n_err++; $display("FAIL full_sp: got %0d want 0", sp); end
    tick(); tick();
    n_cmp++; if (stack_err !== 1'b1) begin n_err++; $display("FAIL overflow_err: got %b want 1", stack_err); end
    n_cmp++; if (sp !== 3'd1)        begin n_err++; $display("FAIL overflow_sp: got %0d want 1", sp); end
    clear_rom();
    rom[0] = 14'h0008;
    do_reset();
    tick(); tick();
    n_cmp++; if (stack_err !== 1'b1) begin n_err++; $display("FAIL underflow_err: got %b want 1", stack_err); end
    n_cmp++; if (sp !== 3'd7)        begin n_err++; $display("FAIL underflow_sp: got %0d want 7", sp); end
    repeat (6) tick();
    n_cmp++; if (stack_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", stack_err); end
    do_reset();
    n_cmp++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b want 0", stack_err); end
  endtask

  task automatic test_stall();
    load_straight();
    do_reset();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (pc !== 11'h001 || ir !== 14'h01A5 || ir_valid !== 1'b1 || sp !== 3'd0)
        begin n_err++; $display("FAIL stall_exec[%0d]: got pc=%h ir=%h v=%b sp=%0d want 001 01A5 1 0", i, pc, ir, ir_valid, sp); end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (ir_valid !== 1'b0 || pc !== 11'h001) begin n_err++; $display("FAIL stall_resume1: got v=%b pc=%h want 0 001", ir_valid, pc); end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (pc !== 11'h001 || ir !== 14'h01A5 || ir_valid !== 1'b0 || sp !== 3'd0)
        begin n_err++; $display("FAIL stall_fetch[%0d]: got pc=%h ir=%h v=%b sp=%0d want 001 01A5 0 0", i, pc, ir, ir_valid, sp); end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (ir !== 14'h0103 || ir_valid !== 1'b1 || pc !== 11'h002)
      begin n_err++; $display("FAIL stall_resume2: got ir=%h v=%b pc=%h want 0103 1 002", ir, ir_valid, pc); end
  endtask

  task automatic test_reset_in_stall();
    clear_rom();
    rom[0] = 14'h2010;
    do_reset();
    tick(); tick(); tick();
    n_cmp++; if (sp !== 3'd1 || ir_valid !== 1'b1) begin n_err++; $display("FAIL rst_stall_setup: got sp=%0d v=%b want 1 1", sp, ir_valid); end
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (pc !== 11'h000)    begin n_err++; $display("FAIL rst_stall_pc: got %h want 000", pc); end
    n_cmp++; if (sp !== 3'd0)       begin n_err++; $display("FAIL rst_stall_sp: got %0d want 0", sp); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_stall_valid: got %b want 0", ir_valid); end
    reset = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = 14'h2FFF;
    rom[11'h7FF] = 14'h0000;
    do_reset();
    tick(); tick();
    n_cmp++; if (rom_addr !== 11'h7FF) begin n_err++; $display("FAIL wrap_goto: got %h want 7FF", rom_addr); end
    tick();
    n_cmp++; if (pc !== 11'h000)       begin n_err++; $display("FAIL wrap_pc: got %h want 000", pc); end
    n_cmp++; if (ir !== 14'h0000)      begin n_err++; $display("FAIL wrap_ir: got %h want 0000", ir); end
    tick(); tick();
    n_cmp++; if (ir !== 14'h2FFF)      begin n_err++; $display("FAIL wrap_next_fetch: got %h want 2FFF", ir); end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    skip  = 1'b0;
    test_reset();
    test_straight_line();
    test_call_return();
    test_skip();
    test_stack_limits();
    test_stall();
    test_reset_in_stall();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter STACK_DEPTH SHALL default to 8 and set the number of return-address entries; it SHALL be a power of two from 2 to 16.
REQ-002 Port clk, input, 1: single clock; all state changes SHALL occur on its rising edge.
REQ-003 Port reset, input, 1: reset is synchronous and active-high.
REQ-004 Port rom_addr, output, 11: program ROM address; SHALL equal the pc register at all times, combinationally.
REQ-005 Port rom_data, input, 14: instruction word returned combinationally by the program ROM for rom_addr.
REQ-006 Port stall, input, 1: while 1, every register in the block SHALL hold its value.
REQ-007 Port skip, input, 1: datapath request to discard the next fetched instruction; sampled only in EXEC.
REQ-008 Port ir, output, 14: instruction register.
REQ-009 Port ir_valid, output, 1: 1 while ir holds an instruction the datapath must execute this cycle.
REQ-010 Port pc, output, 11: current program counter.
REQ-011 Port sp, output, $clog2(STACK_DEPTH): stack pointer.
REQ-012 Port stack_err, output, 1: sticky stack overflow or underflow flag.

Function
REQ-013 The block SHALL be a two-state machine, FETCH and EXEC; FETCH SHALL go to EXEC and EXEC SHALL go to FETCH on every non-stalled clock.
REQ-014 FETCH edge behaviour: ir <= rom_data; pc <= pc+1, modulo 2^11 (7FF wraps to 000).
REQ-015 ir_valid SHALL be 1 only in EXEC with the flush flag clear; it SHALL be 0 in FETCH and in a flushed EXEC.
REQ-016 Decode SHALL apply only in a non-flushed EXEC; it SHALL act on the EXEC->FETCH edge.
REQ-017 GOTO (ir[13:11]=3'b101): pc <= ir[10:0].
REQ-018 CALL (ir[13:11]=3'b100):
- stack[sp] <= pc (already the return address);
- sp <= sp+1, wrapping;
- pc <= ir[10:0].
REQ-019 RETURN (ir=14'h0008) and RETLW (ir[13:10]=4'b1101):
- sp <= sp-1, wrapping;
- pc <= stack[sp-1].
The RETLW literal is the datapath's concern.
REQ-020 All other instructions: pc SHALL keep the value incremented in FETCH.
REQ-021 An internal depth counter (0..STACK_DEPTH) SHALL track occupancy.
REQ-022 A push at full depth SHALL complete as a circular overwrite, keep depth at STACK_DEPTH and set stack_err.
REQ-023 A pop at depth 0 SHALL complete with wrapping, keep depth at 0 and set stack_err.
REQ-024 stack_err SHALL stay set until reset.
REQ-025 skip=1 in a non-flushed EXEC on a non-branch instruction SHALL set the flush flag.
REQ-026 skip SHALL be ignored when ir is GOTO, CALL, RETURN or RETLW, and in a flushed EXEC.
REQ-027 A flushed EXEC SHALL cause no pc redirect and no stack change; it SHALL clear the flush flag.
REQ-028 stall=1 SHALL also hold state, flush flag, depth and stack contents; ir_valid SHALL keep its value, so the datapath must gate its writes with stall.
REQ-029 When stall and reset are both 1, reset SHALL win.

Reset
REQ-030 On any clock edge with reset=1, in any state and even mid-stall:
- pc=0, ir=0, sp=0, depth=0;
- state=FETCH, flush=0, stack_err=0;
- hence ir_valid=0 and rom_addr=0 in the following cycle.
REQ-031 Stack entry contents SHALL NOT require reset.
REQ-032 The first rom_data sample after reset release SHALL be from address 0.

Verification
REQ-033 Straight-line program: ROM 0..5 = 01A5, 0103, 3007, 07A5, 0725, 2805; release reset.
- Required: ir_valid pulses every 2nd cycle with ir = 01A5, 0103, 3007, 07A5, 0725, then 2805 repeating.
- Required: pc stays at 5/6 forever.
REQ-034 Call and return: ROM 0=2010 (CALL 0x10), 0x10=0008.
- Required: after CALL executes, pc=0x010, sp=1, stack[0]=0x001.
- Required: after RETURN executes, pc=0x001, sp=0, stack_err=0.
REQ-035 Skip: assert skip=1 during EXEC of ir at address 2.
- Required: the instruction at address 3 appears with ir_valid=0 and has no effect; the next valid ir is from address 4.
- Required: skip during EXEC of a GOTO is ignored.
REQ-036 Stack limits:
- 9 nested CALLs with STACK_DEPTH=8: stack_err=1 after the 9th, sp=1.
- After reset, a RETURN with an empty stack: stack_err=1, sp=7, stack_err held until reset.
REQ-037 Stall and reset:
- stall=1 for 5 cycles in each state: pc, ir, ir_valid, sp and state unchanged, and the sequence resumes exactly.
- reset=1 during a stall in EXEC after a CALL: next cycle pc=0, sp=0, ir_valid=0.
REQ-038 Wrap: GOTO 0x7FF where ROM 7FF=0000.
- Required: after the fetch, pc=0x000, and the next fetch is from address 0.
